// File: rtl/fp_issue_ctl.sv
// FP issue control: tracks the three-stage FP pipe and the iterative
// divide/sqrt unit, detects RAW/WAW/structural hazards for the op in ID,
// selects operand forwarding and drives the shared FP write port.
module fp_issue_ctl #(
  parameter int DIV_LAT  = 8,
  parameter int SQRT_LAT = 12
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       id_fop,
  input  logic [2:0] id_fc,
  input  logic [4:0] id_fs,
  input  logic [4:0] id_ft,
  input  logic [4:0] id_fd,
  input  logic       id_useb,
  input  logic       id_hold,
  output logic       stl,
  output logic       issue_p,
  output logic       issue_d,
  output logic       div_sq,
  output logic [1:0] fwda,
  output logic [1:0] fwdb,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [4:0] wr_n
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_SQRT = 3'b100
  } fop_e;

  localparam logic [3:0] DIV_L  = 4'(DIV_LAT);
  localparam logic [3:0] SQRT_L = 4'(SQRT_LAT);

  // pipe tracker stages
  logic       e1_v, e2_v, e3_v;
  logic [4:0] e1_d, e2_d, e3_d;

  // divider tracker
  logic       busy;
  logic [4:0] dv_d;
  logic [3:0] cnt;

  logic div_done;
  logic is_pipe, is_ds, op_ok;
  logic raw_a, raw_b, waw, strc;

  assign div_done = busy & (cnt == 4'd1);

  // hazard detection, issue, forwarding and write-port selection
  always_comb begin
    is_pipe = (id_fc == OP_ADD) || (id_fc == OP_SUB) || (id_fc == OP_MUL);
    is_ds   = (id_fc == OP_DIV) || (id_fc == OP_SQRT);
    op_ok   = id_fop && (is_pipe || is_ds);

    raw_a = (e1_v && id_fs == e1_d) || (e2_v && id_fs == e2_d) ||
            (busy && !div_done && id_fs == dv_d);
    raw_b = id_useb &&
            ((e1_v && id_ft == e1_d) || (e2_v && id_ft == e2_d) ||
             (busy && !div_done && id_ft == dv_d));
    waw   = (e1_v && id_fd == e1_d) || (e2_v && id_fd == e2_d) ||
            (busy && id_fd == dv_d);
    // a pipe op issued when cnt==4 would reach E3 in the div_done cycle
    strc  = busy && (is_ds || (is_pipe && cnt == 4'd4));

    stl     = op_ok && (raw_a || raw_b || waw || strc) && !clr;
    issue_p = op_ok && is_pipe && !stl && !id_hold && !clr;
    issue_d = op_ok && is_ds && !stl && !id_hold && !clr;
    div_sq  = issue_d && (id_fc == OP_SQRT);

    fwda = 2'b00;
    if (e3_v && id_fs == e3_d)          fwda = 2'b01;
    else if (div_done && id_fs == dv_d) fwda = 2'b10;

    fwdb = 2'b00;
    if (id_useb) begin
      if (e3_v && id_ft == e3_d)          fwdb = 2'b01;
      else if (div_done && id_ft == dv_d) fwdb = 2'b10;
    end

    wr_en  = e3_v || div_done;
    wr_sel = !e3_v && div_done;
    wr_n   = '0;
    if (e3_v)          wr_n = e3_d;
    else if (div_done) wr_n = dv_d;
  end

  // tracker state: pipe shifts every cycle, divider counts down while busy
  always_ff @(posedge clk) begin
    if (clr) begin
      e1_v <= 1'b0;
      e2_v <= 1'b0;
      e3_v <= 1'b0;
      e1_d <= '0;
      e2_d <= '0;
      e3_d <= '0;
      busy <= 1'b0;
      dv_d <= '0;
      cnt  <= '0;
    end else begin
      e1_v <= issue_p;
      e1_d <= id_fd;
      e2_v <= e1_v;
      e2_d <= e1_d;
      e3_v <= e2_v;
      e3_d <= e2_d;
      if (issue_d) begin
        busy <= 1'b1;
        dv_d <= id_fd;
        cnt  <= (id_fc == OP_SQRT) ? SQRT_L : DIV_L;
      end else if (busy) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_issue_ctl.sv
// Bench for fp_issue_ctl: directed scenarios with literal expectations,
// plus a time-based behavioural model compared on every non-reset cycle.
module tb_fp_issue_ctl;

  localparam int DL = 8;
  localparam int SL = 12;

  logic       clk = 1'b0;
  logic       clr;
  logic       id_fop;
  logic [2:0] id_fc;
  logic [4:0] id_fs, id_ft, id_fd;
  logic       id_useb, id_hold;
  logic       stl, issue_p, issue_d, div_sq;
  logic [1:0] fwda, fwdb;
  logic       wr_en, wr_sel;
  logic [4:0] wr_n;

  int n_chk = 0;
  int n_err = 0;

  fp_issue_ctl #(.DIV_LAT(DL), .SQRT_LAT(SL)) dut (
    .clk(clk), .clr(clr), .id_fop(id_fop), .id_fc(id_fc),
    .id_fs(id_fs), .id_ft(id_ft), .id_fd(id_fd), .id_useb(id_useb),
    .id_hold(id_hold), .stl(stl), .issue_p(issue_p), .issue_d(issue_d),
    .div_sq(div_sq), .fwda(fwda), .fwdb(fwdb), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_n(wr_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (time-based) ----------------
  int         cyc = 0;
  int         pt[$];          // issue cycle of each pipe op in flight
  logic [4:0] pd[$];          // its destination
  bit         dv = 0;         // a divide/sqrt outstanding
  int         dt, dl;         // its issue cycle and latency
  logic [4:0] dd;             // its destination
  bit         m_ip, m_id;

  function automatic bit at_age(input int age, input logic [4:0] r);
    foreach (pt[i]) if (cyc - pt[i] == age && pd[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin : model_cmp
    bit d_busy, d_done, legal, pipe, ds, rawa, rawb, wawm, strm, stlm, has3;
    logic [4:0] w3;
    logic [1:0] fa, fb;
    d_busy = dv && cyc > dt && cyc <= dt + dl;
    d_done = dv && cyc == dt + dl;
    pipe   = id_fc <= 3'd2;
    ds     = id_fc == 3'd3 || id_fc == 3'd4;
    legal  = pipe || ds;
    rawa = at_age(1, id_fs) || at_age(2, id_fs) || (d_busy && !d_done && dd == id_fs);
    rawb = id_useb && (at_age(1, id_ft) || at_age(2, id_ft) ||
                       (d_busy && !d_done && dd == id_ft));
    wawm = at_age(1, id_fd) || at_age(2, id_fd) || (d_busy && dd == id_fd);
    strm = (ds && d_busy) || (pipe && d_busy && cyc == dt + dl - 3);
    stlm = id_fop && legal && (rawa || rawb || wawm || strm);
    m_ip = id_fop && pipe && !stlm && !id_hold && !clr;
    m_id = id_fop && ds && !stlm && !id_hold && !clr;
    fa = at_age(3, id_fs) ? 2'd1 : (d_done && dd == id_fs) ? 2'd2 : 2'd0;
    fb = !id_useb ? 2'd0 : at_age(3, id_ft) ? 2'd1 : (d_done && dd == id_ft) ? 2'd2 : 2'd0;
    has3 = 1'b0;
    w3 = '0;
    foreach (pt[i]) if (cyc - pt[i] == 3) begin has3 = 1'b1; w3 = pd[i]; end
    if (!clr) begin
      chk("m_stl", stl, stlm);
      chk("m_issue_p", issue_p, m_ip);
      chk("m_issue_d", issue_d, m_id);
      chk("m_div_sq", div_sq, m_id && id_fc == 3'd4);
      chk("m_fwda", fwda, fa);
      chk("m_fwdb", fwdb, fb);
      chk("m_wr_en", wr_en, has3 || d_done);
      chk("m_wr_sel", wr_sel, !has3 && d_done);
      chk("m_wr_n", wr_n, has3 ? w3 : d_done ? dd : 5'd0);
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      pt.delete();
      pd.delete();
      dv = 0;
    end else begin
      while (pt.size() > 0 && cyc - pt[0] >= 3) begin
        void'(pt.pop_front());
        void'(pd.pop_front());
      end
      if (dv && cyc >= dt + dl) dv = 0;
      if (m_ip) begin pt.push_back(cyc); pd.push_back(id_fd); end
      if (m_id) begin dv = 1; dt = cyc; dl = (id_fc == 3'd4) ? SL : DL; dd = id_fd; end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic idle;
    id_fop = 0; id_fc = 3'd0; id_fs = 5'd30; id_ft = 5'd30; id_fd = 5'd31;
    id_useb = 1; id_hold = 0;
  endtask

  task automatic set_op(input logic [2:0] fc, input logic [4:0] fs, input logic [4:0] ft,
                        input logic [4:0] fd, input logic useb);
    id_fop = 1; id_fc = fc; id_fs = fs; id_ft = ft; id_fd = fd;
    id_useb = useb; id_hold = 0;
  endtask

  task automatic drain;
    idle;
    repeat (16) step;
  endtask

  initial begin
    clr = 1;
    idle;
    #1;
    repeat (2) step;
    clr = 0;
    settle;
    chk("rst_stl", stl, 0);
    chk("rst_issue_p", issue_p, 0);
    chk("rst_issue_d", issue_d, 0);
    chk("rst_div_sq", div_sq, 0);
    chk("rst_fwda", fwda, 0);
    chk("rst_fwdb", fwdb, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_n", wr_n, 0);
    step;

    // add f3, then dependent mul f4=f3*f1
    set_op(3'd0, 5'd1, 5'd2, 5'd3, 1); settle;
    chk("p_issue", issue_p, 1);
    step;
    set_op(3'd2, 5'd3, 5'd1, 5'd4, 1); settle;
    chk("p_stl_c1", stl, 1);
    step; settle;
    chk("p_stl_c2", stl, 1);
    step; settle;
    chk("p_issue_c3", issue_p, 1);
    chk("p_fwda_c3", fwda, 1);
    chk("p_wr_en_c3", wr_en, 1);
    chk("p_wr_sel_c3", wr_sel, 0);
    chk("p_wr_n_c3", wr_n, 3);
    step; drain;

    // div f5, reader of f5 stalls until div_done and takes forward 10
    set_op(3'd3, 5'd1, 5'd2, 5'd5, 1); settle;
    chk("d_issue", issue_d, 1);
    chk("d_sq", div_sq, 0);
    step;
    set_op(3'd0, 5'd5, 5'd1, 5'd6, 1);
    for (int k = 1; k <= 7; k++) begin
      settle;
      chk("d_rd_stl", stl, 1);
      step;
    end
    settle;
    chk("d_rd_issue", issue_p, 1);
    chk("d_rd_fwda", fwda, 2);
    chk("d_wr_en", wr_en, 1);
    chk("d_wr_sel", wr_sel, 1);
    chk("d_wr_n", wr_n, 5);
    step; drain;

    // div at c0, independent add presented at c5 (counter=4)
    set_op(3'd3, 5'd1, 5'd2, 5'd5, 1); step;
    idle; repeat (4) step;
    set_op(3'd0, 5'd1, 5'd2, 5'd7, 1); settle;
    chk("s_stl_c5", stl, 1);
    step; settle;
    chk("s_stl_c6", stl, 0);
    chk("s_issue_c6", issue_p, 1);
    step; idle; step; settle;
    chk("s_wr_n_c8", wr_n, 5);
    chk("s_wr_sel_c8", wr_sel, 1);
    step; settle;
    chk("s_wr_n_c9", wr_n, 7);
    chk("s_wr_sel_c9", wr_sel, 0);
    step; drain;

    // sqrt at c0, div presented at c12
    set_op(3'd4, 5'd1, 5'd0, 5'd8, 0); settle;
    chk("q_issue", issue_d, 1);
    chk("q_sq", div_sq, 1);
    step; idle; repeat (11) step;
    set_op(3'd3, 5'd2, 5'd3, 5'd9, 1); settle;
    chk("q_stl_c12", stl, 1);
    chk("q_wr_n_c12", wr_n, 8);
    chk("q_wr_sel_c12", wr_sel, 1);
    step; settle;
    chk("q_issue_c13", issue_d, 1);
    chk("q_sq_c13", div_sq, 0);
    step; drain;

    // reset in the middle of a divide
    set_op(3'd3, 5'd1, 5'd2, 5'd10, 1); step;
    idle; repeat (3) step;
    clr = 1; step;
    clr = 0;
    set_op(3'd3, 5'd1, 5'd2, 5'd11, 1); settle;
    chk("r_issue_c5", issue_d, 1);
    step; idle; repeat (2) step; settle;
    chk("r_wr_en_c8", wr_en, 0);
    step; repeat (4) step; settle;
    chk("r_wr_en_c13", wr_en, 1);
    chk("r_wr_n_c13", wr_n, 11);
    step; drain;

    // hold, illegal op, register 0, unused B
    set_op(3'd0, 5'd21, 5'd22, 5'd0, 1); id_hold = 1; settle;
    chk("h_issue", issue_p, 0);
    chk("h_stl", stl, 0);
    step; id_hold = 0; settle;
    chk("h_issue2", issue_p, 1);
    step;
    set_op(3'd5, 5'd0, 5'd0, 5'd0, 1); settle;
    chk("i_stl", stl, 0);
    chk("i_issue", issue_p, 0);
    step;
    set_op(3'd1, 5'd0, 5'd2, 5'd12, 1); settle;
    chk("z_stl", stl, 1);
    step;
    set_op(3'd4, 5'd2, 5'd0, 5'd13, 0); settle;
    chk("z_fwdb_unused", fwdb, 0);
    chk("z_wr_n", wr_n, 0);
    chk("z_wr_en", wr_en, 1);
    step; drain;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctl.md
FP_ISSUE_CTL -- requirements
Module: fp_issue_ctl

Interface
REQ-001 SHALL have parameter DIV_LAT, default 8, cycles from divide issue to divide result.
REQ-002 SHALL have parameter SQRT_LAT, default 12, cycles from sqrt issue to sqrt result; both latencies are 4..15.
REQ-003 clk  in  1  rising-edge clock, the only clock.
REQ-004 clr  in  1  reset, synchronous, active-high.
REQ-005 id_fop  in  1  ID holds a valid FP arithmetic op.
REQ-006 id_fc  in  3  op code: 000 add, 001 sub, 010 mul, 011 div, 100 sqrt; 101..111 illegal, treated as no-op.
REQ-007 id_fs, id_ft, id_fd  in  5 each  source A, source B and destination FP registers.
REQ-008 id_useb  in  1  op reads id_ft; high for swc1 and all ops except sqrt.
REQ-009 id_hold  in  1  IU freeze; no issue while high.
REQ-010 stl  out  1  FP hazard stall request to IU.
REQ-011 issue_p  out  1  pipelined op (add/sub/mul) enters E1 this cycle.
REQ-012 issue_d  out  1  div/sqrt starts this cycle; div_sq (out 1) is 1 for sqrt.
REQ-013 fwda, fwdb  out  2 each  operand select: 00 register file, 01 E3 result, 10 divider result.
REQ-014 wr_en  out  1  FP result write-port enable; wr_sel (out 1) is 0 pipe, 1 divider; wr_n (out 5) is the written register.

Function
REQ-015 Pipe tracker SHALL be a 3-stage shift register (E1, E2, E3), each stage a valid bit plus dest; it shifts every cycle unconditionally, and E1 loads issue_p/id_fd.
REQ-016 Divider tracker SHALL hold busy, dest, and a 4-bit down-counter.
REQ-017 On issue_d the counter SHALL load the selected latency, and busy SHALL set; the counter decrements each busy cycle.
REQ-018 div_done SHALL be high for exactly the cycle the counter equals 1 (the L-th cycle after issue); busy clears at the end of that cycle.
REQ-019 Pipe write: an op issued in cycle t SHALL produce wr_en=1, wr_sel=0, wr_n=dest in cycle t+3 (the E3 cycle).
REQ-020 Divider write: in the div_done cycle, wr_en=1, wr_sel=1, wr_n=divider dest.
REQ-021 RAW stall: stl SHALL be 1 if a used source equals a valid E1 or E2 dest, or equals the divider dest while busy and not div_done.
REQ-022 Forwarding: a used source equal to a valid E3 dest SHALL select 01.
REQ-023 Forwarding: a used source equal to the divider dest in the div_done cycle SHALL select 10.
REQ-024 If both forwarding matches hold, E3 (01) SHALL win; all other cases select 00; an unused B source forces fwdb=00.
REQ-025 WAW stall: stl SHALL be 1 if id_fd equals a valid E1/E2 dest, or equals the busy divider dest (the div_done cycle included).
REQ-026 Structural stall: a div/sqrt with busy=1 SHALL stall, including in the div_done cycle.
REQ-027 Structural stall: a pipelined op SHALL stall while busy and counter=4, since its E3 would coincide with div_done; wr_en therefore never has two sources.
REQ-028 stl SHALL be forced 0 when id_fop=0 or the op is illegal.
REQ-029 Issue: issue_p = id_fop & pipelined op & ~stl & ~id_hold; issue_d likewise for div/sqrt.
REQ-030 Register 0 SHALL be handled as an ordinary register; no special case.
REQ-031 Hazard outputs SHALL be combinational from ID inputs and tracker state; all tracker state SHALL be registered.

Reset
REQ-032 While clr=1 at a clock edge, all valid bits, busy and the counter SHALL clear, including mid-divide; the in-flight result is discarded and never asserts wr_en.
REQ-033 After reset: stl=0, issue_p=0, issue_d=0, div_sq=0, fwda=fwdb=00, wr_en=0, wr_sel=0, wr_n=0.
REQ-034 Any input in the reset cycle SHALL be ignored.

Verification
REQ-035 add f3 in cycle 0, then mul f4=f3*f1 -> stl=1 in cycles 1 and 2, issue_p in cycle 3 with fwda=01, and wr_en/wr_n=3 in cycle 3.
REQ-036 div f5 (DIV_LAT=8) in cycle 0 -> div_done and wr_en/wr_sel=1/wr_n=5 in cycle 8; a reader of f5 stalls in cycles 1-7 and issues in cycle 8 with fwd=10.
REQ-037 div at cycle 0, add f7 presented in cycle 5 (counter=4) -> stl=1 in cycle 5 only, issue in cycle 6, and no wr_en conflict in cycles 8 or 9.
REQ-038 sqrt at cycle 0, div presented in cycle 12 -> stalled, issues in cycle 13.
REQ-039 clr=1 in cycle 4 of a divide -> busy=0 from cycle 5, no wr_en in cycle 8, and a new div issues in cycle 5.
REQ-040 A source matching both E3 and div_done in the same cycle -> fwd=01.
